// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: hex font, anode codes
// and the blank pattern. All segment patterns are active-high {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    // Anode select codes from the scanner (one-hot-low), digit 0 is rightmost
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    // All segments off, active-high
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex font, entry 0 in the lowest slice, entry F in the highest
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    // Four hex digits plus their decimal-point enables
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
    } disp_word_t;

endpackage

// File: rtl/seven_seg_digit_mux_hex_to_seg.sv
// Combinational hex-digit to seven-segment font lookup (active-high output).
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[hex];

endmodule

// File: rtl/seven_seg_digit_mux.sv
// Seven-segment digit multiplexer. A value is loaded into a pending buffer
// and only copied into the display register when the scanner reaches the
// last digit, so a frame never shows a mix of old and new digits. The digit
// picked by an_in is decoded and registered together with an_in and commit.
module seven_seg_digit_mux
    import seven_seg_pkg::*;
#(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        div_clk,
    input  logic        reset_n,
    input  logic [3:0]  an_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an_out,
    output logic        commit
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic       pend_full;
    disp_word_t pend_q;
    disp_word_t disp_q;
    logic       accept;
    logic       commit_now;

    digit_idx_t sel_idx;
    logic       sel_valid;
    logic [3:0] sel_digit;
    logic       sel_dp;
    logic       lz_blank;
    logic [6:0] font_seg;
    logic [6:0] seg_hi;
    logic       dp_hi;
    logic [6:0] seg_d;
    logic       dp_d;

    logic [6:0] seg_p1;
    logic       dp_p1;
    logic [3:0] an_p1;
    logic       commit_p1;

    assign load_ready = ~pend_full;
    assign accept     = load_valid & load_ready;
    assign commit_now = pend_full & (an_in == AN_DIG3);

    // Pending flag: a new acceptance wins over a commit so the new value stays pending
    always_ff @(posedge div_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_full <= 1'b0;
        end else if (accept) begin
            pend_full <= 1'b1;
        end else if (commit_now) begin
            pend_full <= 1'b0;
        end
    end

    // Pending data is qualified by pend_full, so it needs no reset
    always_ff @(posedge div_clk) begin
        if (accept) begin
            pend_q <= '{data: load_data, dp: load_dp};
        end
    end

    // Display register only changes at the frame boundary
    always_ff @(posedge div_clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= '{data: 16'h0000, dp: 4'b0000};
        end else if (commit_now) begin
            disp_q <= pend_q;
        end
    end

    // Pick the digit addressed by the scanner; unknown anode patterns blank
    always_comb begin
        sel_idx   = DIG0;
        sel_valid = 1'b1;
        case (an_in)
            AN_DIG0: sel_idx = DIG0;
            AN_DIG1: sel_idx = DIG1;
            AN_DIG2: sel_idx = DIG2;
            AN_DIG3: sel_idx = DIG3;
            default: sel_valid = 1'b0;
        endcase
    end

    assign sel_digit = disp_q.data[{sel_idx, 2'b00} +: 4];
    assign sel_dp    = disp_q.dp[sel_idx];

    hex_to_seg u_hex_to_seg (
        .hex (sel_digit),
        .seg (font_seg)
    );

    // Leading-zero blanking: this digit and everything above it is zero and no dp
    always_comb begin
        lz_blank = 1'b0;
        if (BLANK_LZ && (sel_idx != DIG0) && !sel_dp &&
            ((disp_q.data >> {sel_idx, 2'b00}) == 16'h0000)) begin
            lz_blank = 1'b1;
        end
        seg_hi = (sel_valid && !lz_blank) ? font_seg : SEG_BLANK;
        dp_hi  = sel_valid && sel_dp;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d   = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
    end

    // ---- stage p1: outputs registered one cycle after an_in ----
    // Output register keeps seg/dp aligned with the delayed anode select
    always_ff @(posedge div_clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_p1    <= SEG_OFF;
            dp_p1     <= DP_OFF;
            an_p1     <= AN_NONE;
            commit_p1 <= 1'b0;
        end else begin
            seg_p1    <= seg_d;
            dp_p1     <= dp_d;
            an_p1     <= an_in;
            commit_p1 <= commit_now;
        end
    end

    assign seg    = seg_p1;
    assign dp     = dp_p1;
    assign an_out = an_p1;
    assign commit = commit_p1;

endmodule

// File: tb/tb_seven_seg_digit_mux.sv
// Bench for seven_seg_digit_mux: directed scenarios then random traffic,
// all compared against a transaction-level model of the display.
module tb_seven_seg_digit_mux;

    logic        div_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  an_in;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an_out;
    logic        commit;

    int tests = 0;
    int fails = 0;

    // Model state: pending value and shown value
    bit          m_full;
    logic [15:0] m_pdata;
    logic [3:0]  m_pdp;
    logic [15:0] m_ddata;
    logic [3:0]  m_ddp;

    logic [3:0] scan [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 div_clk = ~div_clk;

    seven_seg_digit_mux #(
        .BLANK_LZ       (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .div_clk    (div_clk),
        .reset_n    (reset_n),
        .an_in      (an_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .seg        (seg),
        .dp         (dp),
        .an_out     (an_out),
        .commit     (commit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Expected {dp, seg} on the pins (active-low) for the digit an selects
    function automatic logic [7:0] exp_pins(input logic [3:0] an);
        int i;
        logic [6:0] s;
        logic d;
        i = -1;
        for (int k = 0; k < 4; k++) if (an == scan[k]) i = k;
        if (i < 0) return 8'hFF;
        s = font(4'((m_ddata >> (4 * i)) & 16'hF));
        d = m_ddp[i];
        if (i > 0 && (m_ddata >> (4 * i)) == 0 && !d) s = 7'h00;
        return ~{d, s};
    endfunction

    task automatic model_reset();
        m_full  = 1'b0;
        m_ddata = 16'h0000;
        m_ddp   = 4'b0000;
    endtask

    // One clock with the given inputs; checks ready before and outputs after the edge
    task automatic step(input logic [3:0] an, input logic v, input logic [15:0] d,
                        input logic [3:0] p);
        logic [7:0] e;
        logic ec;
        an_in = an; load_valid = v; load_data = d; load_dp = p;
        chk("load_ready", 32'(load_ready), 32'(!m_full));
        e  = exp_pins(an);
        ec = m_full && (an == 4'b0111);
        if (ec) begin
            m_ddata = m_pdata;
            m_ddp   = m_pdp;
        end
        if (v && !m_full) begin
            m_full = 1'b1; m_pdata = d; m_pdp = p;
        end else if (ec) begin
            m_full = 1'b0;
        end
        @(posedge div_clk); #1;
        chk("seg", 32'(seg), 32'(e[6:0]));
        chk("dp", 32'(dp), 32'(e[7]));
        chk("an_out", 32'(an_out), 32'(an));
        chk("commit", 32'(commit), 32'(ec));
    endtask

    task automatic idle_frame();
        for (int k = 0; k < 4; k++) step(scan[k], 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        reset_n = 1'b0; an_in = 4'b1111; load_valid = 1'b0;
        load_data = 16'h0; load_dp = 4'h0;
        model_reset();
        repeat (3) @(posedge div_clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an_out", 32'(an_out), 32'hF);
        chk("rst_commit", 32'(commit), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        reset_n = 1'b1;

        // Reset display: "0" on digit 0, leading zeros blanked above it
        step(4'b1110, 1'b0, 16'h0, 4'h0);  chk("d0_zero", 32'(seg), 32'h40);
        step(4'b1101, 1'b0, 16'h0, 4'h0);  chk("d1_blank", 32'(seg), 32'h7F);
        step(4'b1011, 1'b0, 16'h0, 4'h0);  chk("d2_blank", 32'(seg), 32'h7F);
        step(4'b0111, 1'b0, 16'h0, 4'h0);  chk("d3_blank", 32'(seg), 32'h7F);

        // Load 12AF mid-frame; held until digit 3
        step(4'b1110, 1'b0, 16'h0, 4'h0);
        step(4'b1101, 1'b1, 16'h12AF, 4'h0);
        chk("ready_low", 32'(load_ready), 32'h0);
        step(4'b1011, 1'b0, 16'h0, 4'h0);  chk("no_early", 32'(seg), 32'h7F);
        step(4'b0111, 1'b0, 16'h0, 4'h0);  chk("commit_pulse", 32'(commit), 32'h1);
        step(4'b1110, 1'b0, 16'h0, 4'h0);  chk("show_F", 32'(seg), 32'h0E);
        chk("commit_once", 32'(commit), 32'h0);
        step(4'b1101, 1'b0, 16'h0, 4'h0);  chk("show_A", 32'(seg), 32'h08);
        step(4'b1011, 1'b0, 16'h0, 4'h0);  chk("show_2", 32'(seg), 32'h24);
        step(4'b0111, 1'b0, 16'h0, 4'h0);  chk("show_1", 32'(seg), 32'h79);

        // 0050 with dp on digit 2
        step(4'b1110, 1'b1, 16'h0050, 4'b0100);
        step(4'b1101, 1'b0, 16'h0, 4'h0);
        step(4'b1011, 1'b0, 16'h0, 4'h0);
        step(4'b0111, 1'b0, 16'h0, 4'h0);
        step(4'b1110, 1'b0, 16'h0, 4'h0);  chk("lz_d0", 32'(seg), 32'h40);
        step(4'b1101, 1'b0, 16'h0, 4'h0);  chk("lz_d1", 32'(seg), 32'h12);
        step(4'b1011, 1'b0, 16'h0, 4'h0);  chk("lz_d2", 32'(seg), 32'h40);
        chk("lz_d2_dp", 32'(dp), 32'h0);
        step(4'b0111, 1'b0, 16'h0, 4'h0);  chk("lz_d3", 32'(seg), 32'h7F);

        // Second load held off, then accepted once the first commits
        step(4'b1110, 1'b1, 16'h3456, 4'h0);
        step(4'b1101, 1'b1, 16'h789A, 4'h1);
        step(4'b1011, 1'b1, 16'h789A, 4'h1);
        step(4'b0111, 1'b1, 16'h789A, 4'h1);
        step(4'b1110, 1'b1, 16'h789A, 4'h1);
        idle_frame();
        idle_frame();

        // Non-select anode patterns blank
        step(4'b1100, 1'b0, 16'h0, 4'h0);  chk("multi_low", 32'({dp, seg}), 32'hFF);
        step(4'b1111, 1'b0, 16'h0, 4'h0);  chk("none_low", 32'({dp, seg}), 32'hFF);

        // Reset with a pending value right before digit 3
        step(4'b1101, 1'b1, 16'hBEEF, 4'hF);
        step(4'b1011, 1'b0, 16'h0, 4'h0);
        reset_n = 1'b0;
        #2;
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_an", 32'(an_out), 32'hF);
        an_in = 4'b0111;
        @(posedge div_clk); #1;
        chk("rst_no_commit", 32'(commit), 32'h0);
        chk("rst_ready_in", 32'(load_ready), 32'h1);
        reset_n = 1'b1;
        model_reset();
        idle_frame();

        // Random traffic, mostly in scan order
        for (int n = 0; n < 400; n++) begin
            logic [3:0] an;
            an = ($urandom_range(0, 9) < 8) ? scan[n % 4] : 4'($urandom);
            step(an, 1'($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
